// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding and
// the width helper used to size the return-stack occupancy counter.
package pcp_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    typedef enum logic [1:0] {
        S_RUN   = ST_RUN,
        S_HALT  = ST_HALT,
        S_FAULT = ST_FAULT
    } state_e;

    // Ceiling log2; the occupancy counter needs clog2(DEPTH)+1 bits to hold DEPTH.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Parametrised LIFO of return addresses, indexed by its own occupancy count.
// Push writes entry[cnt], pop reads entry[cnt-1]; dout always shows the top.
module ret_stack
    import pcp_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 8,
    localparam int CW   = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    localparam int IW = clog2(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = cnt_q[IW-1:0];
    assign rd_idx = wr_idx - IW'(1);
    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign cnt    = cnt_q;
    assign dout   = mem_q[rd_idx];

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            cnt_d         = cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Entries carry no reset: clearing the count empties the stack logically.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/HALT/FAULT state machine, PC register and a
// hardware call/return stack. All outputs come from flops or decoded state.
module pc_sequencer
    import pcp_pkg::*;
#(
    parameter int            AW       = 10,
    parameter int            DEPTH    = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    localparam int           CW       = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          bra,
    input  logic          call,
    input  logic          ret,
    input  logic          hlt,
    input  logic          resume,
    input  logic [AW-1:0] badr,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          fault,
    output logic [CW-1:0] stk_cnt,
    output logic          stk_ovf,
    output logic          stk_unf,
    output logic [1:0]    dbg_state
);

    // Strobes are single-cycle requests sampled on the rising edge; there is no
    // handshake back to the control unit, the next pc is simply visible one edge later.
    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push, pop;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;

    assign pc_inc = pc_q + AW'(1);

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .cnt   (stk_cnt),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_RUN: begin
                // One action per cycle, hlt > ret > call > bra > inc.
                if (hlt) begin
                    state_d = S_HALT;
                end else if (ret) begin
                    if (stk_empty) begin
                        unf_d   = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end else if (call) begin
                    if (stk_full) begin
                        ovf_d   = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        push = 1'b1;
                        pc_d = badr;
                    end
                end else if (bra) begin
                    pc_d = badr;
                end else if (inc) begin
                    pc_d = pc_inc;
                end
            end
            S_HALT: begin
                // Resuming steps past the HLT instruction itself.
                if (resume) begin
                    state_d = S_RUN;
                    pc_d    = pc_inc;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign fault     = (state_q == S_FAULT);
    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a driver queues hand-computed expectations,
// a monitor compares them one edge later; async reset is checked directly.
module tb_pc_sequencer;

    localparam int EW = 22;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_RES  = 6'b000001;
    localparam logic [5:0] S_INC  = 6'b000010;
    localparam logic [5:0] S_BRA  = 6'b000100;
    localparam logic [5:0] S_CALL = 6'b001000;
    localparam logic [5:0] S_RET  = 6'b010000;
    localparam logic [5:0] S_HLT  = 6'b100000;

    logic       clk;
    logic       rst;
    logic       inc, bra, call, ret, hlt, resume;
    logic [9:0] badr;
    logic [9:0] pc;
    logic       halted, fault, stk_ovf, stk_unf;
    logic [3:0] stk_cnt;
    logic [1:0] dbg_state;

    logic       s_inc;
    logic       s_zero;
    logic [3:0] s_badr;
    logic [3:0] s_pc;
    logic       s_halted, s_fault, s_ovf, s_unf;
    logic [3:0] s_cnt;
    logic [1:0] s_dbg;

    logic [EW-1:0] exp_q[$];
    logic [3:0]    exp_spc;
    int            checks;
    int            errors;
    int            sb_idx;

    pc_sequencer #(.AW(10), .DEPTH(8), .RESET_PC(10'd15)) u_dut (
        .clk(clk), .rst(rst), .inc(inc), .bra(bra), .call(call), .ret(ret),
        .hlt(hlt), .resume(resume), .badr(badr), .pc(pc), .halted(halted),
        .fault(fault), .stk_cnt(stk_cnt), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
        .dbg_state(dbg_state)
    );

    pc_sequencer #(.AW(4), .DEPTH(8), .RESET_PC(4'd14)) u_small (
        .clk(clk), .rst(rst), .inc(s_inc), .bra(s_zero), .call(s_zero), .ret(s_zero),
        .hlt(s_zero), .resume(s_zero), .badr(s_badr), .pc(s_pc), .halted(s_halted),
        .fault(s_fault), .stk_cnt(s_cnt), .stk_ovf(s_ovf), .stk_unf(s_unf),
        .dbg_state(s_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step(input logic [5:0] s, input logic [9:0] a, input logic [9:0] e_pc,
                        input logic [1:0] e_hf, input logic [3:0] e_cnt,
                        input logic [1:0] e_fl, input logic s_i);
        @(negedge clk);
        {hlt, ret, call, bra, inc, resume} = s;
        badr  = a;
        s_inc = s_i;
        if (s_i) exp_spc = exp_spc + 4'd1;
        exp_q.push_back({e_pc, e_hf, e_cnt, e_fl, exp_spc});
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, int'(pc), 15);
        chk({tag, "_cnt"}, int'(stk_cnt), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_ovf"}, int'(stk_ovf), 0);
        chk({tag, "_unf"}, int'(stk_unf), 0);
        chk({tag, "_state"}, int'(dbg_state), 0);
        chk({tag, "_small_pc"}, int'(s_pc), 14);
    endtask

    task automatic clear_inputs();
        {hlt, ret, call, bra, inc, resume} = S_NONE;
        badr  = '0;
        s_inc = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #2;
        check_reset_values(tag);
        exp_spc = 4'd14;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        #1;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {pc, halted, fault, stk_cnt, stk_ovf, stk_unf, s_pc};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL step%0d: got pc=%0d h=%b f=%b cnt=%0d ovf=%b unf=%b spc=%0d expected pc=%0d h=%b f=%b cnt=%0d ovf=%b unf=%b spc=%0d",
                         sb_idx, act_v[21:12], act_v[11], act_v[10], act_v[9:6], act_v[5], act_v[4], act_v[3:0],
                         exp_v[21:12], exp_v[11], exp_v[10], exp_v[9:6], exp_v[5], exp_v[4], exp_v[3:0]);
            end
            sb_idx++;
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        sb_idx  = 0;
        exp_spc = 4'd14;
        s_zero  = 1'b0;
        s_badr  = '0;
        rst     = 1'b0;
        clear_inputs();
        #12;
        do_reset("init");

        // sequential inc from RESET_PC; small instance wraps 15 -> 0
        step(S_INC, 10'd0, 10'd16, 2'b00, 4'd0, 2'b00, 1'b1);
        step(S_INC, 10'd0, 10'd17, 2'b00, 4'd0, 2'b00, 1'b1);
        step(S_INC, 10'd0, 10'd18, 2'b00, 4'd0, 2'b00, 1'b0);
        step(S_INC, 10'd0, 10'd19, 2'b00, 4'd0, 2'b00, 1'b0);

        // call / return round trip from pc=5
        step(S_BRA,  10'd4,  10'd4,  2'b00, 4'd0, 2'b00, 1'b0);
        step(S_INC,  10'd0,  10'd5,  2'b00, 4'd0, 2'b00, 1'b0);
        step(S_CALL, 10'd40, 10'd40, 2'b00, 4'd1, 2'b00, 1'b0);
        step(S_INC,  10'd0,  10'd41, 2'b00, 4'd1, 2'b00, 1'b0);
        step(S_INC,  10'd0,  10'd42, 2'b00, 4'd1, 2'b00, 1'b0);
        step(S_RET,  10'd0,  10'd6,  2'b00, 4'd0, 2'b00, 1'b0);

        // halt beats bra/inc; strobes ignored while halted; resume beats hlt
        step(S_BRA,                 10'd20, 10'd20, 2'b00, 4'd0, 2'b00, 1'b0);
        step(S_HLT | S_BRA | S_INC, 10'd99, 10'd20, 2'b10, 4'd0, 2'b00, 1'b0);
        step(S_BRA | S_CALL,        10'd7,  10'd20, 2'b10, 4'd0, 2'b00, 1'b0);
        step(S_RES | S_HLT,         10'd0,  10'd21, 2'b00, 4'd0, 2'b00, 1'b0);

        // fill the stack, pop once, refill, then overflow
        for (int i = 0; i < 8; i++) begin
            step(S_CALL, 10'(100 + 10 * i), 10'(100 + 10 * i), 2'b00, 4'(i + 1), 2'b00, 1'b0);
        end
        step(S_RET,  10'd0,   10'd161, 2'b00, 4'd7, 2'b00, 1'b0);
        step(S_CALL, 10'd500, 10'd500, 2'b00, 4'd8, 2'b00, 1'b0);
        step(S_CALL, 10'd600, 10'd500, 2'b01, 4'd8, 2'b10, 1'b0);
        step(S_BRA,  10'd3,   10'd500, 2'b01, 4'd8, 2'b10, 1'b0);
        step(S_INC,  10'd0,   10'd500, 2'b01, 4'd8, 2'b10, 1'b0);
        step(S_RET | S_RES, 10'd0, 10'd500, 2'b01, 4'd8, 2'b10, 1'b0);
        do_reset("after_ovf");

        // underflow run
        step(S_RET, 10'd0, 10'd15, 2'b01, 4'd0, 2'b01, 1'b0);
        step(S_INC, 10'd0, 10'd15, 2'b01, 4'd0, 2'b01, 1'b0);
        do_reset("after_unf");

        // async reset mid-cycle while halted with three entries stacked
        step(S_CALL, 10'd200, 10'd200, 2'b00, 4'd1, 2'b00, 1'b0);
        step(S_CALL, 10'd210, 10'd210, 2'b00, 4'd2, 2'b00, 1'b0);
        step(S_CALL, 10'd220, 10'd220, 2'b00, 4'd3, 2'b00, 1'b0);
        step(S_HLT,  10'd0,   10'd220, 2'b10, 4'd3, 2'b00, 1'b0);
        @(posedge clk);
        #3;
        clear_inputs();
        rst = 1'b0;
        #1;
        check_reset_values("midcycle");
        exp_spc = 4'd14;
        @(negedge clk);
        rst = 1'b1;
        // stack must be empty after reset, so ret underflows
        step(S_RET, 10'd0, 10'd15, 2'b01, 4'd0, 2'b01, 1'b0);

        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the processor core: it generates PC, and the fetch path reads it each cycle.
- Successor to the fixed 10-bit PC/branch logic. Adds configurable address width, reset vector, a hardware call/return stack, halt/resume and a fault state on stack misuse.
- Sits between the control unit (which issues the inc/bra/call/ret/hlt strobes) and instruction memory.

Parameters:
AW, 10, PC and branch-address width in bits
DEPTH, 8, return-stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset (AW bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
inc  in  1  advance PC by 1 (PC_increment)
bra  in  1  load PC from badr
call  in  1  push PC+1, load PC from badr
ret  in  1  pop stack into PC
hlt  in  1  enter HALT; PC frozen
resume  in  1  leave HALT; PC+1 next cycle
badr  in  AW  branch/call target
pc  out  AW  current program counter
halted  out  1  state==HALT
fault  out  1  state==FAULT
stk_cnt  out  $clog2(DEPTH)+1  occupied stack entries
stk_ovf  out  1  sticky: call with stack full
stk_unf  out  1  sticky: ret with stack empty

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=RUN, stk_cnt=0.
  - stk_ovf=0, stk_unf=0, halted=0, fault=0.
  - Stack contents are don't-care.
- States:
  - RUN: normal sequencing.
  - HALT: pc held.
  - FAULT: pc held; the only exit is reset.
- RUN, one action per cycle, priority hlt > ret > call > bra > inc:
  - hlt -> HALT next cycle; pc unchanged.
  - ret, stk_cnt>0 -> pc=top entry, stk_cnt-1.
  - ret, stk_cnt==0 -> stk_unf=1, FAULT; pc unchanged.
  - call, stk_cnt<DEPTH -> push (pc+1 mod 2^AW), pc=badr, stk_cnt+1.
  - call, stk_cnt==DEPTH -> stk_ovf=1, FAULT; pc unchanged; no push.
  - bra -> pc=badr.
  - inc -> pc=pc+1, wrapping at 2^AW-1 to 0 with no flag.
  - no strobe -> pc held.
- Timing:
  - Every update is registered: the new pc is visible on the clock edge after the strobe.
  - Latency is 1 cycle for all actions.
- HALT:
  - All strobes except resume are ignored.
  - resume -> RUN and pc=pc+1 at the same edge (steps past the HLT instruction).
  - hlt and resume together -> resume wins, since hlt is ignored while in HALT.
- FAULT:
  - All strobes are ignored.
  - fault=1; the sticky flags hold.
- Stack:
  - LIFO register array indexed by stk_cnt.
  - Push writes entry[stk_cnt]; pop reads entry[stk_cnt-1].
  - No simultaneous push and pop: the priority scheme guarantees this.
- Reset mid-operation (including in HALT or FAULT): immediate return to reset values; the stack is logically emptied.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Decomposition:
- Shared package pcp_pkg:
  - state encoding localparams ST_RUN=2'd0, ST_HALT=2'd1, ST_FAULT=2'd2.
  - function clog2 for the stk_cnt width.
- One natural sub-module: ret_stack, the parametrised LIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, cnt, full, empty.
  - The pc_sequencer top holds the state machine and the PC register.

Test Plan:
- Reset release at RESET_PC=15, then inc held for 4 cycles -> pc 15,16,17,18,19; halted=0, fault=0.
- AW=4, pc=15, inc -> pc=0, no flags.
- pc=5, call badr=40 -> pc=40, stk_cnt=1. Then inc x2 -> pc=42. Then ret -> pc=6, stk_cnt=0.
- DEPTH=8: nine nested calls. The first 8 succeed (stk_cnt=8). The 9th sets stk_ovf=1 and fault=1, pc unchanged, and later bra/inc are ignored until reset. Separate run: ret at stk_cnt=0 -> stk_unf=1, fault=1.
- pc=20, hlt+bra+inc in the same cycle -> HALT, pc=20 held. Then resume -> pc=21, halted=0.
- rst pulsed low mid-cycle while in HALT with stk_cnt=3 -> outputs reset immediately, without waiting for a clock edge: pc=RESET_PC, stk_cnt=0, halted=0.
